// File: rtl/gtx_prbs_check_ctrl_pkg.sv
// Shared GTX link constants: word/counter widths, the PRBS-24 seed and taps,
// the checker state encoding and small arithmetic helpers.
package gtx_prbs_check_ctrl_pkg;

    localparam int GTX_WORD_W  = 24;
    localparam int GTX_CNT_W   = 16;
    localparam int GTX_MATCH_W = 4;

    // Transmitter seed; the receive LFSR restarts from the same value.
    localparam logic [GTX_WORD_W-1:0] GTX_INIT_FILL = 24'h4DB62E;

    // Feedback taps x^24 + x^23 + x^22 + x^17 (bits 23, 22, 21, 16).
    localparam logic [GTX_WORD_W-1:0] GTX_LFSR_TAPS = 24'hE10000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_HUNT = 2'd2,
        ST_RUN  = 2'd3
    } state_t;

    function automatic logic [GTX_CNT_W-1:0] sat_inc16(input logic [GTX_CNT_W-1:0] v);
        return (v == {GTX_CNT_W{1'b1}}) ? v : v + 16'd1;
    endfunction

    // One word step: 24 serial shifts, new bit enters at bit 0.
    function automatic logic [GTX_WORD_W-1:0] lfsr_step24(input logic [GTX_WORD_W-1:0] s);
        logic [GTX_WORD_W-1:0] r;
        r = s;
        for (int i = 0; i < GTX_WORD_W; i++) begin
            r = {r[GTX_WORD_W-2:0], ^(r & GTX_LFSR_TAPS)};
        end
        return r;
    endfunction

endpackage

// File: rtl/gtx_prbs_check_ctrl_lfsr.sv
// Expected-data generator: PRBS-24 LFSR advancing one full word per CE.
module gtx_lfsr_r24_c160
    import gtx_prbs_check_ctrl_pkg::*;
#(
    parameter logic [GTX_WORD_W-1:0] INIT_FILL = GTX_INIT_FILL
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  CE,
    output logic [GTX_WORD_W-1:0] DATA
);

    logic [GTX_WORD_W-1:0] lfsr_q;
    logic [GTX_WORD_W-1:0] lfsr_d;

    // Advance by one word when enabled, otherwise hold.
    always_comb begin
        lfsr_d = lfsr_q;
        if (CE) begin
            lfsr_d = lfsr_step24(lfsr_q);
        end
    end

    // LFSR register; reset reloads the seed.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lfsr_q <= INIT_FILL;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign DATA = lfsr_q;

endmodule

// File: rtl/gtx_prbs_check_ctrl.sv
// PRBS-24 receive checker controller: hunts for word alignment against a local
// LFSR, then counts checked and mismatching words for a bounded or open run.
//
// state   | meaning
// ST_IDLE | no test; counters hold last results
// ST_ARM  | one cycle: LFSR reloaded to seed, incoming word ignored
// ST_HUNT | comparing words until SYNC_CNT consecutive matches
// ST_RUN  | locked; counting words and errors, no re-sync
module gtx_prbs_check_ctrl
    import gtx_prbs_check_ctrl_pkg::*;
#(
    parameter logic [GTX_WORD_W-1:0] INIT_FILL = GTX_INIT_FILL,
    parameter int unsigned           SYNC_CNT  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    input  logic                  ABORT,
    input  logic [GTX_CNT_W-1:0]  RUN_LEN,
    input  logic                  RX_VLD,
    input  logic [GTX_WORD_W-1:0] RX_DATA,
    output logic [GTX_WORD_W-1:0] EXP_DATA,
    output logic                  BUSY,
    output logic                  LOCKED,
    output logic                  DONE,
    output logic [GTX_CNT_W-1:0]  WORD_CNT,
    output logic [GTX_CNT_W-1:0]  ERR_CNT
);

    localparam logic [GTX_MATCH_W-1:0] SYNC_LIM = GTX_MATCH_W'(SYNC_CNT);

    state_t                 state_q, state_d;
    logic [GTX_MATCH_W-1:0] match_cnt_q, match_cnt_d;
    logic [GTX_CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic [GTX_CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic [GTX_CNT_W-1:0]   run_len_q, run_len_d;
    logic                   done_q, done_d;
    logic                   arm_q, arm_d;

    logic                   adv;
    logic                   lfsr_rst;
    logic [GTX_WORD_W-1:0]  exp_data;
    logic                   rx_match;
    logic                   sync_hit;
    logic                   run_last;
    logic [GTX_MATCH_W-1:0] match_inc;
    logic [GTX_CNT_W-1:0]   word_inc;
    logic [GTX_CNT_W-1:0]   err_inc;

    assign rx_match  = (RX_DATA == exp_data);
    assign match_inc = match_cnt_q + 4'd1;
    assign sync_hit  = (match_inc == SYNC_LIM);
    assign word_inc  = sat_inc16(word_cnt_q);
    assign err_inc   = sat_inc16(err_cnt_q);
    assign run_last  = (run_len_q != '0) && (word_inc == run_len_q);

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic; ABORT overrides every transition.
    always_comb begin
        state_d = state_q;
        if (ABORT) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (START) state_d = ST_ARM;
                ST_ARM:  state_d = ST_HUNT;
                ST_HUNT: begin
                    if (RX_VLD) begin
                        if (!rx_match)     state_d = ST_ARM;
                        else if (sync_hit) state_d = ST_RUN;
                    end
                end
                ST_RUN:  if (RX_VLD && run_last) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Counter, run-length, LFSR-advance and completion next values.
    always_comb begin
        match_cnt_d = match_cnt_q;
        word_cnt_d  = word_cnt_q;
        err_cnt_d   = err_cnt_q;
        run_len_d   = run_len_q;
        done_d      = 1'b0;
        adv         = 1'b0;
        arm_d       = (state_d == ST_ARM);
        if (!ABORT) begin
            case (state_q)
                ST_IDLE: begin
                    if (START) begin
                        match_cnt_d = '0;
                        word_cnt_d  = '0;
                        err_cnt_d   = '0;
                        run_len_d   = RUN_LEN;
                    end
                end
                ST_HUNT: begin
                    if (RX_VLD) begin
                        if (rx_match) begin
                            adv         = 1'b1;
                            match_cnt_d = match_inc;
                        end else begin
                            match_cnt_d = '0;
                        end
                    end
                end
                ST_RUN: begin
                    if (RX_VLD) begin
                        adv        = 1'b1;
                        word_cnt_d = word_inc;
                        if (!rx_match) err_cnt_d = err_inc;
                        if (run_last)  done_d    = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            match_cnt_q <= '0;
            word_cnt_q  <= '0;
            err_cnt_q   <= '0;
            run_len_q   <= '0;
            done_q      <= 1'b0;
            arm_q       <= 1'b0;
        end else begin
            match_cnt_q <= match_cnt_d;
            word_cnt_q  <= word_cnt_d;
            err_cnt_q   <= err_cnt_d;
            run_len_q   <= run_len_d;
            done_q      <= done_d;
            arm_q       <= arm_d;
        end
    end

    // State-decoded status outputs.
    always_comb begin
        BUSY   = (state_q != ST_IDLE);
        LOCKED = (state_q == ST_RUN);
    end

    assign DONE     = done_q;
    assign WORD_CNT = word_cnt_q;
    assign ERR_CNT  = err_cnt_q;
    assign EXP_DATA = exp_data;

    // arm_q is a flop output and is high for exactly the ARM cycle, so the
    // LFSR shows the seed throughout ARM and releases with CE low.
    assign lfsr_rst = RST | arm_q;

    gtx_lfsr_r24_c160 #(
        .INIT_FILL (INIT_FILL)
    ) u_lfsr (
        .CLK  (CLK),
        .RST  (lfsr_rst),
        .CE   (adv),
        .DATA (exp_data)
    );

endmodule

// File: doc/gtx_prbs_check_ctrl.md
GTX_PRBS_CHECK_CTRL -- requirements
Module: gtx_prbs_check_ctrl

Interface
REQ-001 SHALL have parameter INIT_FILL, default 24'h4DB62E: the seed the expected-data LFSR resets to; equals the transmitter seed.
REQ-002 SHALL have parameter SYNC_CNT, default 4: number of consecutive matching words required for lock (range 1-15).
REQ-003 SHALL have port CLK  input  1  clock; all logic on the rising edge.
REQ-004 SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port START  input  1  single-cycle request to begin a test.
REQ-006 SHALL have port ABORT  input  1  terminates any test; returns to IDLE.
REQ-007 SHALL have port RUN_LEN  input  16  words to check after lock; 0 = continuous until ABORT; sampled on accepted START.
REQ-008 SHALL have port RX_VLD  input  1  RX_DATA qualifier.
REQ-009 SHALL have port RX_DATA  input  24  received PRBS word.
REQ-010 SHALL have port EXP_DATA  output  24  current expected word (LFSR state).
REQ-011 SHALL have ports BUSY, LOCKED, DONE  output  1 each  test active / in RUN / one-cycle completion pulse.
REQ-012 SHALL have ports WORD_CNT, ERR_CNT  output  16 each  words checked in RUN / mismatching words in RUN.

Function
REQ-013 SHALL implement states IDLE, ARM, HUNT, RUN.
REQ-014 IDLE: START -> ARM, clearing WORD_CNT, ERR_CNT and the match counter; START outside IDLE SHALL be ignored.
REQ-015 ARM: lasts exactly one cycle, resets the LFSR to INIT_FILL, discards any RX_VLD word, then -> HUNT.
REQ-016 HUNT: on RX_VLD with RX_DATA==EXP_DATA, advance LFSR one step and increment match counter; reaching SYNC_CNT -> RUN the next cycle.
REQ-017 HUNT: on RX_VLD with mismatch, clear match counter -> ARM.
REQ-018 HUNT: cycles without RX_VLD SHALL hold LFSR and match counter.
REQ-019 RUN: every RX_VLD advances LFSR one step and increments WORD_CNT; a mismatch also increments ERR_CNT; no re-sync on errors.
REQ-020 ERR_CNT and WORD_CNT SHALL saturate at 16'hFFFF (WORD_CNT only reachable when RUN_LEN==0).
REQ-021 RUN with RUN_LEN!=0: on the RX_VLD cycle taking WORD_CNT to RUN_LEN, the next cycle SHALL pulse DONE for one cycle and enter IDLE.
REQ-022 Compare latency: ERR_CNT/WORD_CNT update the cycle after the RX_VLD word; EXP_DATA presents the next expected word that same cycle.
REQ-023 BUSY SHALL be high in ARM, HUNT, RUN; LOCKED high only in RUN.
REQ-024 ABORT SHALL take priority over all other events in every state: next cycle IDLE, no DONE pulse, counters held.
REQ-025 START and ABORT together in IDLE: ABORT wins, stay IDLE.
REQ-026 Counters SHALL hold their final values in IDLE until the next accepted START.

Reset
REQ-027 RST SHALL force IDLE, BUSY=0, LOCKED=0, DONE=0, WORD_CNT=0, ERR_CNT=0, match counter=0, EXP_DATA=INIT_FILL, asynchronously, including mid-test.
REQ-028 First START after RST release SHALL behave identically to any later START.

Structure
REQ-029 State encoding and default INIT_FILL SHALL live in the shared GTX package with the other link constants.
REQ-030 Expected data SHALL come from one instance of sub-module gtx_lfsr_r24_c160 (polynomial 24,23,22,17, 24 bits/step); its reset = RST OR registered ARM flag, its CE = advance strobe.

Verification
REQ-031 Reset: assert RST mid-RUN -> all outputs at reset values next edge, EXP_DATA=24'h4DB62E.
REQ-032 Clean run: SYNC_CNT=4, RUN_LEN=8, model-driven error-free stream from seed -> LOCKED after 4 words, DONE one cycle after 8th RUN word, WORD_CNT=8, ERR_CNT=0.
REQ-033 Errors: same run with bit 0 flipped on RUN words 2, 5, 7 -> ERR_CNT=3, WORD_CNT=8, LFSR stays aligned (no extra errors).
REQ-034 Hunt failure: first word 24'h000001 -> ARM, one word discarded, then correct stream -> lock after 4 matches.
REQ-035 Gaps: RX_VLD toggled every other cycle in HUNT and RUN -> identical counts to REQ-032.
REQ-036 Abort/saturation: RUN_LEN=0, all-inverted stream after lock for 70000 words -> ERR_CNT=16'hFFFF; ABORT -> IDLE, no DONE, counters held.
